// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//
// Instruction decode stage of a 5-stage RV32I pipeline.
//
// The stage takes the IF/ID pipeline register and decodes the instruction into
// ALU, memory and writeback controls plus a sign-extended immediate. It fetches
// operands from the register file's combinational read ports. A writeback to the
// same register in the same cycle is bypassed into the operands. A load-use
// hazard against the instruction now in EX raises a stall request. The decoded
// bundle is registered into the ID/EX pipeline register.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   stall, flush          downstream hold / redirect bubble for ID/EX
//   if_id_*               PC, raw instruction and valid flag from IF/ID
//   rs1_addr, rs2_addr    register file read addresses (combinational)
//   rs1_data, rs2_data    register file read data (combinational)
//   wb_*                  writeback port, used for same-cycle bypass
//   hazard_stall          load-use stall request to IF (combinational)
//   id_ex_*               registered decoded bundle for the execute stage
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] if_id_pc,
    input  logic [31:0]     if_id_instruction,
    input  logic            if_id_valid,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic            wb_reg_write,
    output logic            hazard_stall,
    output logic            id_ex_valid,
    output logic            id_ex_illegal,
    output logic [XLEN-1:0] id_ex_pc,
    output logic [XLEN-1:0] id_ex_rs1_data,
    output logic [XLEN-1:0] id_ex_rs2_data,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [4:0]      id_ex_rs1_addr,
    output logic [4:0]      id_ex_rs2_addr,
    output logic [4:0]      id_ex_rd_addr,
    output logic [3:0]      id_ex_alu_op,
    output logic [2:0]      id_ex_funct3,
    output logic            id_ex_alu_src,
    output logic            id_ex_pc_src_a,
    output logic            id_ex_mem_read,
    output logic            id_ex_mem_write,
    output logic            id_ex_reg_write,
    output logic            id_ex_mem_to_reg,
    output logic            id_ex_branch,
    output logic            id_ex_jump
);

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // ALU operation encoding seen by EX
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_addr;

    assign opcode   = if_id_instruction[6:0];
    assign rd_addr  = if_id_instruction[11:7];
    assign funct3   = if_id_instruction[14:12];
    assign funct7   = if_id_instruction[31:25];
    assign rs1_addr = if_id_instruction[19:15];
    assign rs2_addr = if_id_instruction[24:20];

    // Immediate candidates for every format, all sign-extended from instr[31]
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{(XLEN-12){if_id_instruction[31]}}, if_id_instruction[31:20]};
    assign imm_s = {{(XLEN-12){if_id_instruction[31]}}, if_id_instruction[31:25],
                    if_id_instruction[11:7]};
    assign imm_b = {{(XLEN-13){if_id_instruction[31]}}, if_id_instruction[31],
                    if_id_instruction[7], if_id_instruction[30:25],
                    if_id_instruction[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){if_id_instruction[31]}}, if_id_instruction[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){if_id_instruction[31]}}, if_id_instruction[31],
                    if_id_instruction[19:12], if_id_instruction[20],
                    if_id_instruction[30:21], 1'b0};

    // Decoded controls before the illegal-instruction squash
    logic [3:0]      dec_alu_op;
    logic            dec_alu_src;
    logic            dec_pc_src_a;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_reg_write;
    logic            dec_mem_to_reg;
    logic            dec_branch;
    logic            dec_jump;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic [3:0]      arith_op;

    // Shared funct3 -> ALU op map for OP and OP-IMM. instr[30] picks SRA over
    // SRL; SUB vs ADD is only meaningful on OP and is resolved in the decoder.
    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000:  arith_op = ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = if_id_instruction[30] ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    // Main decoder. Every illegal encoding ends with dec_illegal set; the
    // write/memory controls are then forced low below so a bad instruction
    // can never change architectural state.
    always_comb begin
        dec_alu_op     = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_pc_src_a   = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_illegal    = 1'b0;
        dec_imm        = '0;
        case (opcode)
            OPC_LUI: begin
                dec_alu_op    = ALU_PASSB;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_imm       = imm_u;
            end
            OPC_AUIPC: begin
                dec_alu_src   = 1'b1;
                dec_pc_src_a  = 1'b1;
                dec_reg_write = 1'b1;
                dec_imm       = imm_u;
            end
            OPC_JAL: begin
                dec_alu_src   = 1'b1;
                dec_pc_src_a  = 1'b1;
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_imm       = imm_j;
            end
            OPC_JALR: begin
                dec_alu_src   = 1'b1;
                dec_pc_src_a  = 1'b1;
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_imm       = imm_i;
            end
            OPC_BRANCH: begin
                dec_alu_op  = ALU_SUB;
                dec_branch  = 1'b1;
                dec_imm     = imm_b;
                dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_imm        = imm_i;
                dec_illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                 (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_imm       = imm_s;
                dec_illegal   = (funct3 == 3'b011) || funct3[2];
            end
            OPC_OP_IMM: begin
                dec_alu_op    = arith_op;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_imm       = imm_i;
                // Shift-immediates reuse the upper immediate bits as funct7
                if (funct3 == 3'b001) begin
                    dec_illegal = (funct7 != F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    dec_illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                end
            end
            OPC_OP: begin
                dec_reg_write = 1'b1;
                if (funct7 == F7_ZERO) begin
                    dec_alu_op = arith_op;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_alu_op = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                // Single in-order hart with no caches: FENCE is a plain NOP
                dec_imm = imm_i;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (dec_illegal) begin
            dec_mem_read   = 1'b0;
            dec_mem_write  = 1'b0;
            dec_reg_write  = 1'b0;
            dec_mem_to_reg = 1'b0;
            dec_branch     = 1'b0;
            dec_jump       = 1'b0;
        end
    end

    // Operand selection: x0 is hard zero, then a same-cycle writeback to the
    // register being read overrides the (stale) register file value.
    logic [XLEN-1:0] op1_value;
    logic [XLEN-1:0] op2_value;

    always_comb begin
        op1_value = rs1_data;
        op2_value = rs2_data;
        if (rs1_addr == 5'd0) begin
            op1_value = '0;
        end else if (wb_reg_write && wb_rd_addr == rs1_addr) begin
            op1_value = wb_rd_data;
        end
        if (rs2_addr == 5'd0) begin
            op2_value = '0;
        end else if (wb_reg_write && wb_rd_addr == rs2_addr) begin
            op2_value = wb_rd_data;
        end
    end

    // Load-use hazard: the load in EX cannot forward in time for the
    // instruction in ID. A flush discards ID anyway, so it masks the request.
    // The reset term keeps the request low even while the registers clear.
    assign hazard_stall = reset && id_ex_valid && id_ex_mem_read &&
                          (id_ex_rd_addr != 5'd0) &&
                          ((id_ex_rd_addr == rs1_addr) || (id_ex_rd_addr == rs2_addr)) &&
                          if_id_valid && !flush;

    // A bubble is inserted on flush (highest priority after reset), or when
    // not stalled and either a load-use hazard is pending or IF/ID is empty.
    logic insert_bubble;
    logic load_bundle;

    assign insert_bubble = flush || (!stall && (hazard_stall || !if_id_valid));
    assign load_bundle   = !flush && !stall && !hazard_stall && if_id_valid;

    // ID/EX pipeline register. Bubbles clear data fields too so downstream
    // never sees stale operands attached to a non-valid slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex_valid      <= 1'b0;
            id_ex_illegal    <= 1'b0;
            id_ex_pc         <= '0;
            id_ex_rs1_data   <= '0;
            id_ex_rs2_data   <= '0;
            id_ex_imm        <= '0;
            id_ex_rs1_addr   <= '0;
            id_ex_rs2_addr   <= '0;
            id_ex_rd_addr    <= '0;
            id_ex_alu_op     <= '0;
            id_ex_funct3     <= '0;
            id_ex_alu_src    <= 1'b0;
            id_ex_pc_src_a   <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_branch     <= 1'b0;
            id_ex_jump       <= 1'b0;
        end else if (insert_bubble) begin
            id_ex_valid      <= 1'b0;
            id_ex_illegal    <= 1'b0;
            id_ex_pc         <= '0;
            id_ex_rs1_data   <= '0;
            id_ex_rs2_data   <= '0;
            id_ex_imm        <= '0;
            id_ex_rs1_addr   <= '0;
            id_ex_rs2_addr   <= '0;
            id_ex_rd_addr    <= '0;
            id_ex_alu_op     <= '0;
            id_ex_funct3     <= '0;
            id_ex_alu_src    <= 1'b0;
            id_ex_pc_src_a   <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_branch     <= 1'b0;
            id_ex_jump       <= 1'b0;
        end else if (load_bundle) begin
            id_ex_valid      <= 1'b1;
            id_ex_illegal    <= dec_illegal;
            id_ex_pc         <= if_id_pc;
            id_ex_rs1_data   <= op1_value;
            id_ex_rs2_data   <= op2_value;
            id_ex_imm        <= dec_imm;
            id_ex_rs1_addr   <= rs1_addr;
            id_ex_rs2_addr   <= rs2_addr;
            id_ex_rd_addr    <= rd_addr;
            id_ex_alu_op     <= dec_alu_op;
            id_ex_funct3     <= funct3;
            id_ex_alu_src    <= dec_alu_src;
            id_ex_pc_src_a   <= dec_pc_src_a;
            id_ex_mem_read   <= dec_mem_read;
            id_ex_mem_write  <= dec_mem_write;
            id_ex_reg_write  <= dec_reg_write;
            id_ex_mem_to_reg <= dec_mem_to_reg;
            id_ex_branch     <= dec_branch;
            id_ex_jump       <= dec_jump;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//
// Directed testbench for id_stage. Each task drives one scenario and
// compares the DUT outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        wb_reg_write;
    logic        hazard_stall;
    logic        id_ex_valid;
    logic        id_ex_illegal;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_rs1_data;
    logic [31:0] id_ex_rs2_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs1_addr;
    logic [4:0]  id_ex_rs2_addr;
    logic [4:0]  id_ex_rd_addr;
    logic [3:0]  id_ex_alu_op;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_alu_src;
    logic        id_ex_pc_src_a;
    logic        id_ex_mem_read;
    logic        id_ex_mem_write;
    logic        id_ex_reg_write;
    logic        id_ex_mem_to_reg;
    logic        id_ex_branch;
    logic        id_ex_jump;

    int checks;
    int failures;

    id_stage #(.XLEN(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .wb_rd_addr        (wb_rd_addr),
        .wb_rd_data        (wb_rd_data),
        .wb_reg_write      (wb_reg_write),
        .hazard_stall      (hazard_stall),
        .id_ex_valid       (id_ex_valid),
        .id_ex_illegal     (id_ex_illegal),
        .id_ex_pc          (id_ex_pc),
        .id_ex_rs1_data    (id_ex_rs1_data),
        .id_ex_rs2_data    (id_ex_rs2_data),
        .id_ex_imm         (id_ex_imm),
        .id_ex_rs1_addr    (id_ex_rs1_addr),
        .id_ex_rs2_addr    (id_ex_rs2_addr),
        .id_ex_rd_addr     (id_ex_rd_addr),
        .id_ex_alu_op      (id_ex_alu_op),
        .id_ex_funct3      (id_ex_funct3),
        .id_ex_alu_src     (id_ex_alu_src),
        .id_ex_pc_src_a    (id_ex_pc_src_a),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_mem_write   (id_ex_mem_write),
        .id_ex_reg_write   (id_ex_reg_write),
        .id_ex_mem_to_reg  (id_ex_mem_to_reg),
        .id_ex_branch      (id_ex_branch),
        .id_ex_jump        (id_ex_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr);
        if_id_pc          = pc;
        if_id_instruction = instr;
        if_id_valid       = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (id_ex_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_valid: got %b expected 0", id_ex_valid);
        end
        checks++;
        if ({id_ex_pc, id_ex_imm, id_ex_rs1_data, id_ex_rs2_data} !== 128'd0) begin
            failures++; $display("[TB] FAIL reset_data: got %h expected 0",
                                 {id_ex_pc, id_ex_imm, id_ex_rs1_data, id_ex_rs2_data});
        end
        checks++;
        if ({id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch,
             id_ex_jump, id_ex_illegal, id_ex_alu_op} !== 10'd0) begin
            failures++; $display("[TB] FAIL reset_ctrl: got %b expected 0",
                                 {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
                                  id_ex_branch, id_ex_jump, id_ex_illegal, id_ex_alu_op});
        end
        checks++;
        if (hazard_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_hazard: got %b expected 0", hazard_stall);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_decode_addi();
        // addi x1, x0, 5 ; rs1_data driven non-zero to prove x0 reads as 0
        present(32'h100, 32'h00500093);
        rs1_data = 32'hDEADBEEF;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'h77;
        #1;
        checks++;
        if (rs1_addr !== 5'd0 || rs2_addr !== 5'd5) begin
            failures++; $display("[TB] FAIL addi_rs_addr: got %0d/%0d expected 0/5", rs1_addr, rs2_addr);
        end
        tick();
        checks++;
        if (id_ex_imm !== 32'd5 || id_ex_rd_addr !== 5'd1 || id_ex_pc !== 32'h100) begin
            failures++; $display("[TB] FAIL addi_fields: got imm=%h rd=%0d pc=%h expected 5/1/100",
                                 id_ex_imm, id_ex_rd_addr, id_ex_pc);
        end
        checks++;
        if ({id_ex_valid, id_ex_alu_op, id_ex_alu_src, id_ex_reg_write, id_ex_mem_read,
             id_ex_illegal} !== {1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("[TB] FAIL addi_ctrl: got v=%b op=%0d src=%b rw=%b mr=%b ill=%b",
                                 id_ex_valid, id_ex_alu_op, id_ex_alu_src, id_ex_reg_write,
                                 id_ex_mem_read, id_ex_illegal);
        end
        checks++;
        if (id_ex_rs1_data !== 32'd0) begin
            failures++; $display("[TB] FAIL addi_x0_read: got %h expected 0", id_ex_rs1_data);
        end
        rs1_data = 32'd0; wb_reg_write = 1'b0;
    endtask

    task automatic test_other_decodes();
        // lui x1, 0x12345
        present(32'h104, 32'h123450B7);
        tick();
        checks++;
        if (id_ex_imm !== 32'h12345000 || id_ex_alu_op !== 4'd10 || id_ex_alu_src !== 1'b1
            || id_ex_reg_write !== 1'b1) begin
            failures++; $display("[TB] FAIL lui: got imm=%h op=%0d src=%b rw=%b expected 12345000/10/1/1",
                                 id_ex_imm, id_ex_alu_op, id_ex_alu_src, id_ex_reg_write);
        end
        // sub x2, x1, x2
        present(32'h108, 32'h40208133);
        tick();
        checks++;
        if (id_ex_alu_op !== 4'd1 || id_ex_alu_src !== 1'b0 || id_ex_imm !== 32'd0
            || id_ex_rd_addr !== 5'd2) begin
            failures++; $display("[TB] FAIL sub: got op=%0d src=%b imm=%h rd=%0d expected 1/0/0/2",
                                 id_ex_alu_op, id_ex_alu_src, id_ex_imm, id_ex_rd_addr);
        end
        // sw x2, 12(x1)
        present(32'h10C, 32'h0020A623);
        tick();
        checks++;
        if (id_ex_imm !== 32'd12 || id_ex_mem_write !== 1'b1 || id_ex_reg_write !== 1'b0
            || id_ex_funct3 !== 3'b010 || id_ex_mem_read !== 1'b0) begin
            failures++; $display("[TB] FAIL sw: got imm=%h mw=%b rw=%b f3=%b mr=%b expected c/1/0/010/0",
                                 id_ex_imm, id_ex_mem_write, id_ex_reg_write, id_ex_funct3, id_ex_mem_read);
        end
    endtask

    task automatic test_branch();
        // beq x1, x2, -4
        present(32'h110, 32'hFE208EE3);
        tick();
        checks++;
        if (id_ex_imm !== 32'hFFFFFFFC) begin
            failures++; $display("[TB] FAIL beq_imm: got %h expected fffffffc", id_ex_imm);
        end
        checks++;
        if (id_ex_branch !== 1'b1 || id_ex_alu_op !== 4'd1 || id_ex_reg_write !== 1'b0
            || id_ex_rs1_addr !== 5'd1 || id_ex_rs2_addr !== 5'd2) begin
            failures++; $display("[TB] FAIL beq_ctrl: got br=%b op=%0d rw=%b rs=%0d/%0d expected 1/1/0/1/2",
                                 id_ex_branch, id_ex_alu_op, id_ex_reg_write, id_ex_rs1_addr, id_ex_rs2_addr);
        end
    endtask

    task automatic test_illegal();
        present(32'h114, 32'hFFFFFFFF);
        tick();
        checks++;
        if (id_ex_illegal !== 1'b1 || id_ex_valid !== 1'b1 || id_ex_reg_write !== 1'b0
            || id_ex_mem_write !== 1'b0 || id_ex_mem_read !== 1'b0) begin
            failures++; $display("[TB] FAIL illegal_opcode: got ill=%b v=%b rw=%b mw=%b mr=%b expected 1/1/0/0/0",
                                 id_ex_illegal, id_ex_valid, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read);
        end
        // load with undefined funct3 = 011
        present(32'h118, 32'h0080B103);
        tick();
        checks++;
        if (id_ex_illegal !== 1'b1 || id_ex_mem_read !== 1'b0 || id_ex_reg_write !== 1'b0) begin
            failures++; $display("[TB] FAIL illegal_load_f3: got ill=%b mr=%b rw=%b expected 1/0/0",
                                 id_ex_illegal, id_ex_mem_read, id_ex_reg_write);
        end
    endtask

    task automatic test_load_use();
        // lw x2, 8(x1) then add x3, x2, x1
        present(32'h200, 32'h0080A103);
        tick();
        checks++;
        if (id_ex_mem_read !== 1'b1 || id_ex_mem_to_reg !== 1'b1 || id_ex_imm !== 32'd8) begin
            failures++; $display("[TB] FAIL lw_decode: got mr=%b m2r=%b imm=%h expected 1/1/8",
                                 id_ex_mem_read, id_ex_mem_to_reg, id_ex_imm);
        end
        present(32'h204, 32'h001101B3);
        #1;
        checks++;
        if (hazard_stall !== 1'b1) begin
            failures++; $display("[TB] FAIL load_use_stall: got %b expected 1", hazard_stall);
        end
        tick();
        checks++;
        if (id_ex_valid !== 1'b0 || hazard_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL load_use_bubble: got v=%b hz=%b expected 0/0",
                                 id_ex_valid, hazard_stall);
        end
        tick();
        checks++;
        if (id_ex_valid !== 1'b1 || id_ex_rs1_addr !== 5'd2 || id_ex_rs2_addr !== 5'd1
            || id_ex_rd_addr !== 5'd3 || id_ex_pc !== 32'h204) begin
            failures++; $display("[TB] FAIL load_use_issue: got v=%b rs=%0d/%0d rd=%0d pc=%h expected 1/2/1/3/204",
                                 id_ex_valid, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr, id_ex_pc);
        end
    endtask

    task automatic test_stall_vs_hazard();
        present(32'h300, 32'h0080A103);
        tick();
        present(32'h304, 32'h001101B3);
        stall = 1'b1;
        #1;
        tick();
        checks++;
        if (id_ex_pc !== 32'h300 || id_ex_mem_read !== 1'b1 || hazard_stall !== 1'b1) begin
            failures++; $display("[TB] FAIL stall_hold: got pc=%h mr=%b hz=%b expected 300/1/1",
                                 id_ex_pc, id_ex_mem_read, hazard_stall);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (id_ex_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_then_bubble: got %b expected 0", id_ex_valid);
        end
        tick();
    endtask

    task automatic test_flush();
        // flush beats a pending load-use hazard
        present(32'h400, 32'h0080A103);
        tick();
        present(32'h404, 32'h001101B3);
        flush = 1'b1;
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_masks_hazard: got %b expected 0", hazard_stall);
        end
        tick();
        checks++;
        if (id_ex_valid !== 1'b0 || id_ex_mem_read !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_hazard_bubble: got v=%b mr=%b expected 0/0",
                                 id_ex_valid, id_ex_mem_read);
        end
        // flush with a valid addi present
        present(32'h408, 32'h00500093);
        tick();
        checks++;
        if (id_ex_valid !== 1'b0 || id_ex_reg_write !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_addi: got v=%b rw=%b expected 0/0",
                                 id_ex_valid, id_ex_reg_write);
        end
        flush = 1'b0;
        if_id_valid = 1'b0;
        tick();
        checks++;
        if (id_ex_valid !== 1'b0 || id_ex_reg_write !== 1'b0) begin
            failures++; $display("[TB] FAIL invalid_input: got v=%b rw=%b expected 0/0",
                                 id_ex_valid, id_ex_reg_write);
        end
    endtask

    task automatic test_bypass();
        // add x3, x1, x1 with register file returning stale 0 for x1
        present(32'h500, 32'h001081B3);
        rs1_data = 32'd0; rs2_data = 32'd0;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd1; wb_rd_data = 32'h00001234;
        tick();
        checks++;
        if (id_ex_rs1_data !== 32'h00001234 || id_ex_rs2_data !== 32'h00001234) begin
            failures++; $display("[TB] FAIL bypass_hit: got %h/%h expected 1234/1234",
                                 id_ex_rs1_data, id_ex_rs2_data);
        end
        wb_rd_addr = 5'd0;
        tick();
        checks++;
        if (id_ex_rs1_data !== 32'd0) begin
            failures++; $display("[TB] FAIL bypass_rd0: got %h expected 0", id_ex_rs1_data);
        end
        wb_rd_addr = 5'd5; rs1_data = 32'h55; rs2_data = 32'h66;
        tick();
        checks++;
        if (id_ex_rs1_data !== 32'h55 || id_ex_rs2_data !== 32'h66) begin
            failures++; $display("[TB] FAIL bypass_miss: got %h/%h expected 55/66",
                                 id_ex_rs1_data, id_ex_rs2_data);
        end
        wb_reg_write = 1'b0; rs1_data = 32'd0; rs2_data = 32'd0;
    endtask

    task automatic test_reset_midstream();
        present(32'h600, 32'h00500093);
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (id_ex_valid !== 1'b0 || id_ex_imm !== 32'd0 || id_ex_pc !== 32'd0
            || id_ex_reg_write !== 1'b0 || id_ex_alu_src !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_async: got v=%b imm=%h pc=%h rw=%b src=%b expected all 0",
                                 id_ex_valid, id_ex_imm, id_ex_pc, id_ex_reg_write, id_ex_alu_src);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (id_ex_valid !== 1'b1 || id_ex_imm !== 32'd5 || id_ex_pc !== 32'h600) begin
            failures++; $display("[TB] FAIL reset_resume: got v=%b imm=%h pc=%h expected 1/5/600",
                                 id_ex_valid, id_ex_imm, id_ex_pc);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        if_id_pc = 32'd0;
        if_id_instruction = 32'h00000013;
        if_id_valid = 1'b0;
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        wb_rd_addr = 5'd0;
        wb_rd_data = 32'd0;
        wb_reg_write = 1'b0;

        test_reset();
        test_decode_addi();
        test_other_decodes();
        test_branch();
        test_illegal();
        test_load_use();
        test_stall_vs_hazard();
        test_flush();
        test_bypass();
        test_reset_midstream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
